// File: rtl/random_ack_gen.sv
// Random acknowledge generator: each channel acks pending requests using a shared
// 16-bit LFSR; BOUNDED mode adds a stall guard that forces an ack after MAX_STALL misses.
module random_ack_gen #(
    parameter int unsigned CH        = 3,
    parameter int unsigned THRESH    = 50,
    parameter int unsigned MAX_STALL = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    io_mode,
    input  logic [CH-1:0] io_req,
    output logic [CH-1:0] io_ack,
    output logic [CH-1:0] io_forced
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ALWAYS  = 2'b01,
        MODE_RANDOM  = 2'b10,
        MODE_BOUNDED = 2'b11
    } mode_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  THRESH_B = 8'(THRESH);
    localparam logic [7:0]  STALL_B  = 8'(MAX_STALL);

    mode_t         mode;
    logic [15:0]   lfsr;
    logic [CH-1:0] hit;
    logic [CH-1:0] force_on;
    logic [CH-1:0] ack_nxt;

    always_comb mode = mode_t'(io_mode);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr      <= SEED_EFF;
            io_ack    <= '0;
            io_forced <= '0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            io_ack    <= ack_nxt;
            io_forced <= force_on & ~hit;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [6:0] win;
        logic [7:0] cnt;
        logic       h;
        logic       f;
        logic       a;

        // 7-bit window starting at bit g, wrapping around the 16-bit register
        for (genvar b = 0; b < 7; b++) begin : g_win
            assign win[b] = lfsr[(g + b) % 16];
        end

        always_comb begin
            h = ({1'b0, win} < THRESH_B);
            f = (mode == MODE_BOUNDED) && io_req[g] && (cnt == STALL_B);
            a = 1'b0;
            case (mode)
                MODE_OFF:     a = 1'b0;
                MODE_ALWAYS:  a = io_req[g];
                MODE_RANDOM:  a = io_req[g] & h;
                MODE_BOUNDED: a = io_req[g] & (h | f);
                default:      a = 1'b0;
            endcase
        end

        assign hit[g]      = h;
        assign force_on[g] = f;
        assign ack_nxt[g]  = a;

        // Stall counter runs in every mode so entering BOUNDED can force immediately.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt <= '0;
            end else if (io_req[g] && !a) begin
                cnt <= (cnt == STALL_B) ? cnt : cnt + 8'd1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_random_ack_gen.sv
// Directed bench for random_ack_gen: vector table plus stall-guard, reset and LFSR model sequences.
module tb_random_ack_gen;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [2:0]  req;
    logic [15:0] req16;
    logic [2:0]  ack0, frc0, ack1, frc1, ack2, frc2;
    logic [15:0] ack3, frc3;
    logic [15:0] m0, m3;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] req;
        logic [2:0] hi;
        logic [2:0] lo;
    } vec_t;

    vec_t tbl [10];

    always #5 clock = ~clock;

    random_ack_gen #(.CH(3), .THRESH(50), .MAX_STALL(16), .SEED(16'hACE1)) u0 (
        .clock(clock), .reset(reset), .io_mode(mode), .io_req(req), .io_ack(ack0), .io_forced(frc0));
    random_ack_gen #(.CH(3), .THRESH(0), .MAX_STALL(4), .SEED(16'hACE1)) u1 (
        .clock(clock), .reset(reset), .io_mode(mode), .io_req(req), .io_ack(ack1), .io_forced(frc1));
    random_ack_gen #(.CH(3), .THRESH(128), .MAX_STALL(16), .SEED(16'hACE1)) u2 (
        .clock(clock), .reset(reset), .io_mode(mode), .io_req(req), .io_ack(ack2), .io_forced(frc2));
    random_ack_gen #(.CH(16), .THRESH(50), .MAX_STALL(16), .SEED(16'h0000)) u3 (
        .clock(clock), .reset(reset), .io_mode(mode), .io_req(req16), .io_ack(ack3), .io_forced(frc3));

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    // Window for channel i is bits i..i+6 of the register, wrapping at 16.
    function automatic logic [15:0] hits(input logic [15:0] r, input int thresh);
        logic [31:0] rr;
        logic [15:0] h;
        int          w;
        rr = {r, r};
        h  = '0;
        for (int i = 0; i < 16; i++) begin
            w    = int'((rr >> i) & 32'h7f);
            h[i] = (w < thresh);
        end
        return h;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m0 <= 16'hACE1;
            m3 <= 16'h0001;
        end else begin
            m0 <= lfsr_next(m0);
            m3 <= lfsr_next(m3);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] e0, e3, h;
        int mism0, mism3, mism2, any1;
        int acks [3];
        int run_d [3];
        int run_m [3];
        int max_d [3];
        int max_m [3];
        int lo_cnt, hi_cnt;

        tbl[0] = '{2'b00, 3'b111, 3'b000, 3'b000};
        tbl[1] = '{2'b01, 3'b101, 3'b101, 3'b101};
        tbl[2] = '{2'b10, 3'b011, 3'b011, 3'b000};
        tbl[3] = '{2'b10, 3'b110, 3'b110, 3'b000};
        tbl[4] = '{2'b01, 3'b111, 3'b111, 3'b111};
        tbl[5] = '{2'b11, 3'b010, 3'b010, 3'b000};
        tbl[6] = '{2'b11, 3'b111, 3'b111, 3'b000};
        tbl[7] = '{2'b00, 3'b000, 3'b000, 3'b000};
        tbl[8] = '{2'b01, 3'b010, 3'b010, 3'b010};
        tbl[9] = '{2'b10, 3'b101, 3'b101, 3'b000};

        // reset held two cycles with ALWAYS / 101 applied
        reset = 1'b1;
        mode  = 2'b01;
        req   = 3'b101;
        req16 = '0;
        tick();
        check("rst_ack_e1", 16'(ack0), 16'h0);
        check("rst_frc_e1", 16'(frc0), 16'h0);
        tick();
        check("rst_ack_e2", 16'(ack0), 16'h0);
        reset = 1'b0;
        check("rel_ack", 16'(ack0), 16'h0);
        tick();
        check("always_ack", 16'(ack0), 16'h5);
        check("always_frc", 16'(frc0), 16'h0);

        for (int k = 0; k < 10; k++) begin
            mode = tbl[k].mode;
            req  = tbl[k].req;
            tick();
            check($sformatf("tbl%0d_hi_ack", k), 16'(ack2), 16'(tbl[k].hi));
            check($sformatf("tbl%0d_lo_ack", k), 16'(ack1), 16'(tbl[k].lo));
            check($sformatf("tbl%0d_frc", k), {10'd0, frc1, frc2}, 16'h0);
        end

        // forced ack every MAX_STALL+1 cycles with THRESH=0
        do_reset();
        mode = 2'b11;
        tick();
        req = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("bnd_ack_e%0d", k), 16'(ack1[0]), 16'((k == 5 || k == 10) ? 1 : 0));
            check($sformatf("bnd_frc_e%0d", k), 16'(frc1[0]), 16'((k == 5 || k == 10) ? 1 : 0));
        end

        // request dropped for one cycle at cnt=3
        do_reset();
        mode = 2'b11;
        tick();
        req = 3'b001;
        tick();
        tick();
        tick();
        req = 3'b000;
        tick();
        req = 3'b001;
        for (int k = 5; k <= 9; k++) begin
            tick();
            check($sformatf("drop_ack_e%0d", k), 16'(ack1[0]), 16'((k == 9) ? 1 : 0));
            check($sformatf("drop_frc_e%0d", k), 16'(frc1[0]), 16'((k == 9) ? 1 : 0));
        end

        // reset pulse at cnt=3
        do_reset();
        mode = 2'b11;
        tick();
        req = 3'b001;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rpulse_ack_e4", 16'(ack1[0]), 16'h0);
        for (int k = 5; k <= 9; k++) begin
            tick();
            check($sformatf("rpulse_ack_e%0d", k), 16'(ack1[0]), 16'((k == 9) ? 1 : 0));
        end

        // RANDOM extremes: THRESH=128 mirrors req, THRESH=0 never acks
        do_reset();
        mode  = 2'b10;
        mism2 = 0;
        for (int k = 0; k < 200; k++) begin
            req = 3'($urandom);
            e0  = 16'(req);
            tick();
            if (16'(ack2) !== e0) mism2++;
        end
        check("thr128_mirror_mism", 16'(mism2), 16'h0);
        req  = 3'b111;
        any1 = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (ack1 !== 3'b000) any1++;
        end
        check("thr0_acks", 16'(any1), 16'h0);
        mode = 2'b11;
        tick();
        check("enter_bnd_ack", 16'(ack1), 16'h7);
        check("enter_bnd_frc", 16'(frc1), 16'h7);
        tick();
        check("enter_bnd_next", 16'(ack1), 16'h0);

        // LFSR model and distribution
        do_reset();
        mode  = 2'b10;
        req   = 3'b111;
        req16 = 16'hFFFF;
        tick();
        check("seed0_first_ack", ack3, 16'hFBFF);
        mism0 = 0;
        mism3 = 0;
        for (int c = 0; c < 3; c++) begin
            acks[c]  = 0;
            run_d[c] = 0;
            run_m[c] = 0;
            max_d[c] = 0;
            max_m[c] = 0;
        end
        req16 = 16'($urandom);
        for (int n = 0; n < 65535; n++) begin
            h  = hits(m0, 50);
            e0 = {13'd0, h[2:0] & req};
            h  = hits(m3, 50);
            e3 = h & req16;
            tick();
            if (16'(ack0) !== e0) mism0++;
            if (n < 10000 && ack3 !== e3) mism3++;
            for (int c = 0; c < 3; c++) begin
                if (ack0[c]) begin
                    acks[c]++;
                    run_d[c] = 0;
                end else begin
                    run_d[c]++;
                    if (run_d[c] > max_d[c]) max_d[c] = run_d[c];
                end
                if (e0[c]) run_m[c] = 0;
                else begin
                    run_m[c]++;
                    if (run_m[c] > max_m[c]) max_m[c] = run_m[c];
                end
            end
            req16 = 16'($urandom);
        end
        check("model_u0_mism", 16'(mism0), 16'h0);
        check("model_u3_mism", 16'(mism3), 16'h0);
        lo_cnt = int'(65535.0 * (50.0 / 128.0 - 0.02));
        hi_cnt = int'(65535.0 * (50.0 / 128.0 + 0.02));
        for (int c = 0; c < 3; c++) begin
            check_range($sformatf("rate_ch%0d", c), acks[c], lo_cnt, hi_cnt);
            check_range($sformatf("zero_run_ch%0d", c), max_d[c], 0, max_m[c]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
